bufg_switch_seq: RTL and testbench
==================================

Name: bufg_switch_seq

Overview:
- Sequencer that owns the select/enable pins (S0, S1, CE0, CE1) of one BUFGCTRL global clock buffer and performs glitch-free switchover between its I0 and I1 inputs on request.
- Sits beside the clock-buffer instance.
- Runs on an always-present free-running clock, not on the muxed output.
- Replaces the static tie-offs of S/CE with a handshaked, timed break-before-make sequence.

Parameters:
- GUARD, 2: cycles between an S pin change and the matching CE pin change (>=1).
- SETTLE, 8: dead cycles with both inputs deselected before enabling the new input (>=1).
- INIT_SEL, 0: input (0 = I0, 1 = I1) selected out of reset.

Ports:
- clk  in  1  free-running sequencer clock, independent of the BUFGCTRL output.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  switch request valid.
- req_sel  in  1  requested input: 0 = I0, 1 = I1.
- req_ready  out  1  request accepted when req_valid & req_ready at a rising clk edge.
- s0  out  1  to BUFGCTRL S0.
- ce0  out  1  to BUFGCTRL CE0.
- s1  out  1  to BUFGCTRL S1.
- ce1  out  1  to BUFGCTRL CE1.
- cur_sel  out  1  currently selected input; valid whenever busy = 0.
- busy  out  1  switch sequence in progress.
- done  out  1  one-cycle pulse when a request completes.

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low. All outputs are registered.
- Reset values:
  - s0 = ce0 = (INIT_SEL == 0); s1 = ce1 = (INIT_SEL == 1).
  - cur_sel = INIT_SEL; busy = 0; done = 0; req_ready = 1.
  - Internal state = IDLE, counter = 0.
- States: IDLE, DROP_S, DROP_CE, GAP, RAISE_S, RAISE_CE.
- req_ready is 1 only in IDLE. Requests outside IDLE are not accepted and not queued; the requester holds req_valid.
- Same-input request: accepted at edge E with req_sel == cur_sel → no pin change, state stays IDLE, done = 1 for the one cycle following E, busy stays 0.
- Switch request: accepted at edge E with req_sel != cur_sel; old = cur_sel, new = req_sel.
  - Edge E: s_old <= 0, busy <= 1, counter loads GUARD-1, state DROP_S.
  - Edge E+GUARD: ce_old <= 0, counter loads SETTLE-1, state GAP.
  - Edge E+GUARD+SETTLE: s_new <= 1, counter loads GUARD-1, state RAISE_CE.
  - Edge E+2*GUARD+SETTLE: ce_new <= 1, cur_sel <= new, busy <= 0, done <= 1 (one cycle), state IDLE, req_ready <= 1.
  - Defaults: 12 cycles from acceptance to done.
- States DROP_CE and RAISE_S are transient labels only. Implementation may merge them, but the pin timing above is normative.
- Invariants:
  - Never both (s0 & ce0) and (s1 & ce1) high simultaneously.
  - Between the edges E+GUARD and E+GUARD+SETTLE, all four pins except the unused S/CE of each side are low, i.e. no input is passed through.
  - cur_sel always matches the input whose S and CE are both high when busy = 0.
- Counter: width $clog2(max(GUARD, SETTLE)+1). Decrements to 0, then transitions on the next edge. No wrap-around is possible.
- Back-to-back requests: a new request can be accepted on the edge after done (ready is high in the done cycle).
- Reset mid-switch: pins snap asynchronously to the INIT_SEL pattern, the in-flight request is discarded, and no done is issued.
- req_sel is sampled only at acceptance; later changes are ignored.

Optional Feature:
- Macro: BUFGSW_LOCK_EN.
- When defined: adds input port lock (1 bit, after req_sel).
  - While lock = 1, req_ready = 0 even in IDLE.
  - lock does not abort or stall an in-progress switch.
  - lock has no effect on done.
- When undefined: no lock port; req_ready = (state == IDLE).

Test Plan:
- Reset with INIT_SEL=0, hold rst_n low 3 cycles → s0=ce0=1, s1=ce1=0, cur_sel=0, busy=0, req_ready=1, done=0.
- Request req_sel=1 accepted at edge E, defaults → s0 falls at E, ce0 at E+2, s1 rises at E+10, ce1 at E+12; done one cycle after E+12; cur_sel=1; busy high for exactly 12 cycles. Monitor asserts no overlap of selections.
- Request req_sel=0 while cur_sel=0 → done pulse the next cycle, pins unchanged, busy never asserted.
- req_valid held high during a switch with toggling req_sel → req_ready=0 throughout. Next acceptance occurs on the edge after done, using the req_sel sampled at that edge. A switch back to 0 completes in 12 cycles.
- Assert rst_n low at E+5 of a 0→1 switch → pins immediately return to s0=ce0=1, s1=ce1=0; no done; cur_sel=0.
- With BUFGSW_LOCK_EN: lock=1 in IDLE with req_valid=1 → no acceptance for 20 cycles. Release lock → accepted at the next edge. lock=1 raised mid-switch → switch still completes at E+12.

Source files
------------

// File: rtl/bufg_switch_seq.sv
// bufg_switch_seq
// Drives the S0/S1/CE0/CE1 pins of a single BUFGCTRL and switches it
// between I0 and I1 without glitches, using a break-before-make sequence:
// drop the old S, then the old CE, wait with nothing selected, then raise
// the new S and finally the new CE.
// Runs on a free-running clock, never on the muxed buffer output.
//
// Optional feature (macro BUFGSW_LOCK_EN): adds a 'lock' input that holds
// req_ready low while asserted. It does not affect a switch already running.

module bufg_switch_seq #(
    parameter int GUARD    = 2,   // cycles between an S change and the matching CE change
    parameter int SETTLE   = 8,   // dead cycles with both inputs deselected
    parameter int INIT_SEL = 0    // input selected out of reset (0 = I0, 1 = I1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_sel,
`ifdef BUFGSW_LOCK_EN
    input  logic lock,
`endif
    output logic req_ready,
    output logic s0,
    output logic ce0,
    output logic s1,
    output logic ce1,
    output logic cur_sel,
    output logic busy,
    output logic done
);

    localparam int MAXC = (GUARD > SETTLE) ? GUARD : SETTLE;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic          INIT_BIT  = (INIT_SEL != 0);
    localparam logic [CW-1:0] GUARD_LD  = CW'(GUARD - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);

    // DROP_CE and RAISE_S are folded into the counter expiry of DROP_S and
    // GAP, so the machine only ever visits IDLE, DROP_S, GAP and RAISE_CE.
    typedef enum logic [2:0] {
        IDLE,
        DROP_S,
        DROP_CE,
        GAP,
        RAISE_S,
        RAISE_CE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          tgt;
    logic          ready_q;
    logic          accept;

    // The lock gate stays combinational so that a raised lock blocks the
    // very next edge, with no one-cycle window where a request slips in.
`ifdef BUFGSW_LOCK_EN
    assign req_ready = ready_q & ~lock;
`else
    assign req_ready = ready_q;
`endif

    assign accept = req_valid & req_ready;

    // Sequencer: owns all pin registers, the countdown and the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tgt     <= INIT_BIT;
            s0      <= ~INIT_BIT;
            ce0     <= ~INIT_BIT;
            s1      <= INIT_BIT;
            ce1     <= INIT_BIT;
            cur_sel <= INIT_BIT;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_sel == cur_sel) begin
                            done <= 1'b1;
                        end else begin
                            tgt <= req_sel;
                            if (cur_sel) s1 <= 1'b0;
                            else         s0 <= 1'b0;
                            busy    <= 1'b1;
                            ready_q <= 1'b0;
                            cnt     <= GUARD_LD;
                            state   <= DROP_S;
                        end
                    end
                end
                DROP_S: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (cur_sel) ce1 <= 1'b0;
                        else         ce0 <= 1'b0;
                        cnt   <= SETTLE_LD;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (tgt) s1 <= 1'b1;
                        else     s0 <= 1'b1;
                        cnt   <= GUARD_LD;
                        state <= RAISE_CE;
                    end
                end
                RAISE_CE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (tgt) ce1 <= 1'b1;
                        else     ce0 <= 1'b1;
                        cur_sel <= tgt;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bufg_switch_seq.sv
// tb_bufg_switch_seq
// Directed bench for bufg_switch_seq with default parameters
// (GUARD=2, SETTLE=8, INIT_SEL=0). Lock scenarios are included when
// BUFGSW_LOCK_EN is defined.

module tb_bufg_switch_seq;

    logic clk;
    logic rst_n;
    logic req_valid;
    logic req_sel;
    logic lock;
    logic req_ready;
    logic s0, ce0, s1, ce1;
    logic cur_sel;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;

    bufg_switch_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_sel   (req_sel),
`ifdef BUFGSW_LOCK_EN
        .lock      (lock),
`endif
        .req_ready (req_ready),
        .s0        (s0),
        .ce0       (ce0),
        .s1        (s1),
        .ce1       (ce1),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .done      (done)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic sel);
        req_valid = valid;
        req_sel   = sel;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived pin pattern {s0,ce0,s1,ce1}, k cycles after acceptance:
    // old S low from k=0, old CE low from k=2, new S high from k=10,
    // new CE high from k=12.
    function automatic logic [3:0] pins_exp(input int k, input logic new_sel);
        logic s_old, ce_old, s_new, ce_new;
        s_old  = 1'b0;
        ce_old = (k < 2);
        s_new  = (k >= 10);
        ce_new = (k >= 12);
        return new_sel ? {s_old, ce_old, s_new, ce_new} : {s_new, ce_new, s_old, ce_old};
    endfunction

    // Takes the acceptance edge, then follows the switch to completion.
    task automatic observeSwitch(input logic new_sel, input bit toggle, input int lock_at);
        int busy_cycles;
        busy_cycles = 0;
        step();
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) step();
            if (k == lock_at) lock = 1'b1;
            checkOutput("sw_pins",  {28'd0, s0, ce0, s1, ce1}, {28'd0, pins_exp(k, new_sel)});
            checkOutput("sw_busy",  busy,      (k < 12));
            checkOutput("sw_done",  done,      (k == 12));
            checkOutput("sw_ready", req_ready, (k == 12) && !lock);
            if (busy) busy_cycles++;
            if (toggle && k < 12) req_sel = ~req_sel;
        end
        checkOutput("sw_busy_len", busy_cycles, 12);
        checkOutput("sw_cur_sel",  cur_sel,     new_sel);
    endtask

    // Continuous invariants: never two inputs enabled, cur_sel tracks pins.
    always @(negedge clk) begin
        checkOutput("no_overlap", (s0 & ce0) & (s1 & ce1), 1'b0);
        if (!busy)
            checkOutput("cur_sel_pins", {30'd0, s1 & ce1, s0 & ce0}, cur_sel ? 32'd2 : 32'd1);
    end

    initial begin
        rst_n = 1'b0;
        lock  = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Reset state
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checkOutput("rst_pins",  {28'd0, s0, ce0, s1, ce1}, 32'hC);
        checkOutput("rst_cur",   cur_sel,   1'b0);
        checkOutput("rst_busy",  busy,      1'b0);
        checkOutput("rst_ready", req_ready, 1'b1);
        checkOutput("rst_done",  done,      1'b0);

        // Switch 0 -> 1
        $display("[TB] switch 0->1");
        applyStimulus(1'b1, 1'b1);
        observeSwitch(1'b1, 1'b0, -1);
        applyStimulus(1'b0, 1'b0);
        step();
        checkOutput("post_done", done, 1'b0);
        checkOutput("post_pins", {28'd0, s0, ce0, s1, ce1}, 32'h3);

        // Switch 1 -> 0 with req_valid held and req_sel toggling
        $display("[TB] switch 1->0 with held request");
        applyStimulus(1'b1, 1'b0);
        observeSwitch(1'b0, 1'b1, -1);

        // Back-to-back: accepted on the edge after done, sel sampled there
        req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        req_sel   = 1'b0;
        checkOutput("b2b_busy", busy, 1'b1);
        checkOutput("b2b_pins", {28'd0, s0, ce0, s1, ce1}, {28'd0, pins_exp(0, 1'b1)});
        repeat (5) step();
        checkOutput("mid_pins", {28'd0, s0, ce0, s1, ce1}, {28'd0, pins_exp(5, 1'b1)});

        // Reset in the middle of the switch
        $display("[TB] reset mid-switch");
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pins",  {28'd0, s0, ce0, s1, ce1}, 32'hC);
        checkOutput("midrst_cur",   cur_sel,   1'b0);
        checkOutput("midrst_busy",  busy,      1'b0);
        checkOutput("midrst_ready", req_ready, 1'b1);
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            checkOutput("midrst_nodone", done, 1'b0);
            checkOutput("midrst_hold", {28'd0, s0, ce0, s1, ce1}, 32'hC);
        end

        // Same-input request
        $display("[TB] same-input request");
        applyStimulus(1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0);
        checkOutput("same_done",  done,      1'b1);
        checkOutput("same_busy",  busy,      1'b0);
        checkOutput("same_ready", req_ready, 1'b1);
        checkOutput("same_pins",  {28'd0, s0, ce0, s1, ce1}, 32'hC);
        step();
        checkOutput("same_done2", done, 1'b0);
        checkOutput("same_busy2", busy, 1'b0);

`ifdef BUFGSW_LOCK_EN
        // Lock holds off acceptance, then a lock raised mid-switch is ignored
        $display("[TB] lock");
        lock = 1'b1;
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput("lock_ready", req_ready, 1'b0);
            checkOutput("lock_busy",  busy,      1'b0);
            checkOutput("lock_pins",  {28'd0, s0, ce0, s1, ce1}, 32'hC);
        end
        lock = 1'b0;
        observeSwitch(1'b1, 1'b0, 3);
        lock = 1'b0;
        applyStimulus(1'b0, 1'b0);
        step();
        checkOutput("lock_post_done", done, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
